seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a hex value, scans one digit per scan period, and drives active-low segment and anode lines. It supports per-digit blanking and leading-zero suppression. New values are double-buffered and committed only at frame boundaries, so the display never shows a partly updated value. The block sits between datapath/status registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, clocks per digit slot; must be >= 1 (1 = advance every clock).

Ports:
clk  in  1  system clock; one clock domain only.
rst  in  1  asynchronous, active-high reset.
value  in  4*NUM_DIGITS  hex value to show; nibble i drives digit i; digit 0 is least significant.
load  in  1  one-clock strobe; value is captured into the staging register on this edge.
digit_en  in  NUM_DIGITS  per-digit enable, sampled live; 0 blanks that digit.
lz_suppress  in  1  1 = blank leading zero digits, sampled live.
seg  out  7  active-low segments; bit0=a ... bit6=g; registered.
an  out  NUM_DIGITS  active-low one-hot anode select; all ones = nothing lit; registered.
frame_done  out  1  one-clock pulse when a staged value is committed to the display register.
pending  out  1  1 while a staged value is waiting for commit.

Behaviour:
- Reset (async, immediate, valid mid-scan):
  - prescaler=0, idx=0, staging=0, disp=0, pending=0, frame_done=0.
  - seg=7'h7F, an=all ones.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where prescaler==SCAN_DIV-1.
- idx: advances on tick and wraps NUM_DIGITS-1 -> 0. Frame end = tick while idx==NUM_DIGITS-1.
- load: staging<=value and pending<=1.
- Commit: at frame end with pending=1, disp<=staging, pending<=0, frame_done=1 for exactly that one cycle.
- Load coinciding with a commit cycle: the commit uses the old staging. New staging is captured and pending stays 1 for the next frame end.
- Back-to-back loads before a commit: the last one wins. Only one commit and one frame_done pulse follow.
- Segment encoding of a nibble, active-low hex:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Blanking, evaluated for digit idx:
  - blank if digit_en[idx]=0;
  - or if lz_suppress=1, idx>0, and every disp nibble from idx up to NUM_DIGITS-1 is 0.
  - Digit 0 is never zero-suppressed, so value 0 shows a single "0".
- Output register, updated every clock from current idx/disp:
  - unblanked: an = ~(1<<idx), seg = encode(disp nibble idx).
  - blanked: an = all ones, seg = 7'h7F.
  - Outputs lag idx and disp changes by exactly 1 clock.
- NUM_DIGITS=1: idx stays 0. Frame end = every tick.
- SCAN_DIV=1: tick is constant 1 and idx advances every clock.
- No glitches: an is never multi-hot, and never shows a digit from disp mixed with staging.

Test Plan:
- Reset check (NUM_DIGITS=4, SCAN_DIV=4): assert rst mid-scan -> seg=7F, an=F, pending=0 and frame_done=0 immediately, without waiting for a clk edge. After release, first tick lands 4 clocks later.
- Load/commit: load value=16'h12AF at idx=1 -> pending=1 until frame end (idx 3 tick). Then exactly one frame_done pulse. Next frame shows an=E/seg=0E, an=D/seg=08, an=B/seg=24, an=7/seg=79.
- Leading zeros: disp=16'h0030, lz_suppress=1 -> digits 3 and 2 blank (an=F, seg=7F), digit1 seg=30, digit0 seg=40. Same value with lz_suppress=0 -> digits 3 and 2 show seg=40.
- Zero value: disp=0, lz_suppress=1 -> only digit0 lit with seg=40. Set digit_en=4'b1110 -> every slot blank.
- Collision: load A on the commit-cycle edge, then load B two clocks later -> A is not displayed. disp=old staging this frame, then B next frame, with one frame_done per commit.
- Encoding sweep (NUM_DIGITS=1, SCAN_DIV=1): load 0..F in turn -> seg matches the 16-entry table, 1 clock after commit.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered value,
// per-digit blanking and leading-zero suppression; all display outputs registered.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    tick;
  logic                    frame_end;

  logic [3:0]              nib;
  logic                    en_cur;
  logic                    upper_zero;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   idx_onehot;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick      = (prescaler == PS_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Digit select and zero-suppression scan over the committed value only,
  // so staging can never leak into what is shown.
  always_comb begin
    nib        = 4'h0;
    en_cur     = 1'b0;
    upper_zero = 1'b1;
    idx_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib           = disp[4*i +: 4];
        en_cur        = digit_en[i];
        idx_onehot[i] = 1'b1;
      end
      if ((IW'(i) >= idx) && (disp[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    blank = !en_cur || (lz_suppress && (idx != '0) && upper_zero);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      staging    <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg        <= 7'h7F;
      an         <= '1;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

      frame_done <= 1'b0;
      if (frame_end && pending) begin
        disp       <= staging;
        pending    <= 1'b0;
        frame_done <= 1'b1;
      end
      // A load on the commit edge wins over the clear: the new value waits a frame.
      if (load) begin
        staging <= value;
        pending <= 1'b1;
      end

      seg <= blank ? 7'h7F : seg_encode(nib);
      an  <= blank ? '1 : ~idx_onehot;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a 4-digit/div-4 and a 1-digit/div-1 instance checked
// every cycle against a cycle-count based reference model, plus directed scenarios.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] value4;
  logic        load4;
  logic [3:0]  en4;
  logic        lz4;
  logic [6:0]  seg4;
  logic [3:0]  an4;
  logic        fd4;
  logic        pend4;

  logic [3:0]  value1;
  logic        load1;
  logic        en1;
  logic        lz1;
  logic [6:0]  seg1;
  logic        an1;
  logic        fd1;
  logic        pend1;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .value(value4), .load(load4), .digit_en(en4),
    .lz_suppress(lz4), .seg(seg4), .an(an4), .frame_done(fd4), .pending(pend4)
  );

  seg_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .value(value1), .load(load1), .digit_en(en1),
    .lz_suppress(lz1), .seg(seg1), .an(an1), .frame_done(fd1), .pending(pend1)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: index 0 is the 4-digit instance, index 1 the 1-digit one.
  int          m_cyc  [2];
  logic [31:0] m_stg  [2];
  logic [31:0] m_disp [2];
  logic        m_pend [2];
  logic        m_fd   [2];
  logic [6:0]  m_seg  [2];
  logic [7:0]  m_an   [2];

  function automatic int nd(int d);   return (d == 0) ? 4 : 1; endfunction
  function automatic int dv(int d);   return (d == 0) ? 4 : 1; endfunction
  function automatic int in_en(int d); return (d == 0) ? int'(en4) : int'(en1); endfunction
  function automatic bit in_lz(int d); return (d == 0) ? lz4 : lz1; endfunction
  function automatic bit in_load(int d); return (d == 0) ? load4 : load1; endfunction
  function automatic logic [31:0] in_val(int d);
    return (d == 0) ? {16'h0, value4} : {28'h0, value1};
  endfunction

  function automatic int cur_idx(int d);
    return (m_cyc[d] / dv(d)) % nd(d);
  endfunction
  function automatic bit frame_end(int d);
    return ((m_cyc[d] % dv(d)) == dv(d) - 1) && (cur_idx(d) == nd(d) - 1);
  endfunction
  function automatic bit blank(int d);
    int i = cur_idx(d);
    return (((in_en(d) >> i) & 1) == 0) || (in_lz(d) && i > 0 && (m_disp[d] >> (4*i)) == 0);
  endfunction
  function automatic logic [6:0] exp_seg(int d);
    int i = cur_idx(d);
    return blank(d) ? 7'h7F : enc[(m_disp[d] >> (4*i)) & 32'hF];
  endfunction
  function automatic logic [7:0] exp_an(int d);
    int all = (1 << nd(d)) - 1;
    return blank(d) ? 8'(all) : 8'(all ^ (1 << cur_idx(d)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_cyc[d]  <= 0;
        m_stg[d]  <= '0;
        m_disp[d] <= '0;
        m_pend[d] <= 1'b0;
        m_fd[d]   <= 1'b0;
        m_seg[d]  <= 7'h7F;
        m_an[d]   <= 8'((1 << nd(d)) - 1);
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_cyc[d] <= m_cyc[d] + 1;
        m_seg[d] <= exp_seg(d);
        m_an[d]  <= exp_an(d);
        m_fd[d]  <= 1'b0;
        if (frame_end(d) && m_pend[d]) begin
          m_disp[d] <= m_stg[d];
          m_fd[d]   <= 1'b1;
          m_pend[d] <= 1'b0;
        end
        if (in_load(d)) begin
          m_stg[d]  <= in_val(d);
          m_pend[d] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("seg4", 32'(seg4), 32'(m_seg[0]));
      chk("an4", 32'(an4), 32'(m_an[0][3:0]));
      chk("frame_done4", 32'(fd4), 32'(m_fd[0]));
      chk("pending4", 32'(pend4), 32'(m_pend[0]));
      chk("an4_onehot", 32'($countones(~an4) <= 1), 32'd1);
      chk("seg1", 32'(seg1), 32'(m_seg[1]));
      chk("an1", 32'(an1), 32'(m_an[1][0]));
      chk("frame_done1", 32'(fd1), 32'(m_fd[1]));
      chk("pending1", 32'(pend1), 32'(m_pend[1]));
    end
  endtask

  task automatic wait_fd(input string tag);
    for (int k = 0; k < 64 && !fd4; k++) step(1);
    chk(tag, 32'(fd4), 32'd1);
  endtask

  // Align to the start of slot 0, then sample each slot's first displayed cycle.
  task automatic check_frame(input string tag, input logic [3:0][3:0] a, input logic [3:0][6:0] s);
    for (int k = 0; k < 32 && !((m_cyc[0] % 4) == 0 && cur_idx(0) == 0); k++) step(1);
    chk({tag, "_align"}, 32'(cur_idx(0)), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? 1 : 4);
      chk({tag, "_an"}, 32'(an4), 32'(a[i]));
      chk({tag, "_seg"}, 32'(seg4), 32'(s[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nfd;
    value4 = '0; load4 = 1'b0; en4 = 4'hF; lz4 = 1'b0;
    value1 = '0; load1 = 1'b0; en1 = 1'b1; lz1 = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_seg", 32'(seg4), 32'h7F);
    chk("reset_an", 32'(an4), 32'hF);
    chk("reset_fd", 32'(fd4), 32'd0);
    chk("reset_pend", 32'(pend4), 32'd0);
    rst = 1'b0;
    step(4);
    chk("first_tick_before", 32'(an4), 32'hE);
    step(1);
    chk("first_tick_after", 32'(an4), 32'hD);

    // Reset asserted mid-scan with a value pending must act without a clock edge.
    step(3);
    value4 = 16'hBEEF; load4 = 1'b1;
    step(1);
    load4 = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("midreset_seg", 32'(seg4), 32'h7F);
    chk("midreset_an", 32'(an4), 32'hF);
    chk("midreset_pend", 32'(pend4), 32'd0);
    chk("midreset_fd", 32'(fd4), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(4);
    chk("midreset_tick_before", 32'(an4), 32'hE);
    step(1);
    chk("midreset_tick_after", 32'(an4), 32'hD);

    // Load at idx 1, commit at the end of the frame.
    for (int k = 0; k < 32 && cur_idx(0) != 1; k++) step(1);
    value4 = 16'h12AF; load4 = 1'b1;
    step(1);
    load4 = 1'b0;
    chk("load_pending", 32'(pend4), 32'd1);
    wait_fd("commit_12af_fd");
    chk("commit_12af_pend", 32'(pend4), 32'd0);
    check_frame("show_12af", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h79, 7'h24, 7'h08, 7'h0E});

    // Leading-zero suppression.
    value4 = 16'h0030; load4 = 1'b1; lz4 = 1'b1;
    step(1);
    load4 = 1'b0;
    wait_fd("commit_0030_fd");
    check_frame("lz_on", {4'hF, 4'hF, 4'hD, 4'hE}, {7'h7F, 7'h7F, 7'h30, 7'h40});
    lz4 = 1'b0;
    check_frame("lz_off", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h40, 7'h40, 7'h30, 7'h40});

    // Zero value, then digit 0 disabled.
    value4 = 16'h0000; load4 = 1'b1; lz4 = 1'b1;
    step(1);
    load4 = 1'b0;
    wait_fd("commit_zero_fd");
    check_frame("zero_lz", {4'hF, 4'hF, 4'hF, 4'hE}, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    en4 = 4'b1110;
    check_frame("zero_blank", {4'hF, 4'hF, 4'hF, 4'hF}, {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    en4 = 4'hF; lz4 = 1'b0;

    // Collision: A loaded on the commit edge, B two clocks later; A never commits.
    for (int k = 0; k < 32 && cur_idx(0) != 1; k++) step(1);
    value4 = 16'h4321; load4 = 1'b1;
    step(1);
    load4 = 1'b0;
    for (int k = 0; k < 32 && !frame_end(0); k++) step(1);
    chk("collision_align", 32'(frame_end(0)), 32'd1);
    value4 = 16'h8888; load4 = 1'b1;
    step(1);
    load4 = 1'b0;
    chk("collision_fd", 32'(fd4), 32'd1);
    chk("collision_pend", 32'(pend4), 32'd1);
    step(1);
    value4 = 16'h5A5A; load4 = 1'b1;
    step(1);
    load4 = 1'b0;
    nfd = 0;
    repeat (32) begin
      step(1);
      if (fd4) nfd++;
    end
    chk("collision_fd_count", 32'(nfd), 32'd1);
    check_frame("show_5a5a", {4'h7, 4'hB, 4'hD, 4'hE}, {7'h12, 7'h08, 7'h12, 7'h08});

    // Encoding sweep on the single-digit, every-clock instance.
    for (int v = 0; v < 16; v++) begin
      value1 = 4'(v); load1 = 1'b1;
      step(1);
      load1 = 1'b0;
      step(1);
      chk("sweep_fd", 32'(fd1), 32'd1);
      step(1);
      chk("sweep_seg", 32'(seg1), 32'(enc[v]));
      chk("sweep_an", 32'(an1), 32'd0);
    end

    // Random traffic on both instances.
    repeat (400) begin
      load4 = ($urandom_range(0, 7) == 0);
      value4 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) en4 = 4'($urandom);
      if ($urandom_range(0, 15) == 0) en4 = 4'hF;
      if ($urandom_range(0, 15) == 0) lz4 = 1'($urandom);
      load1 = ($urandom_range(0, 3) == 0);
      value1 = 4'($urandom);
      en1 = ($urandom_range(0, 7) != 0);
      lz1 = 1'($urandom);
      step(1);
    end
    load4 = 1'b0; load1 = 1'b0;
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
